// File: rtl/timer_pkg.sv
// Shared definitions for the timer_bank peripheral: register indices and
// CTRL field positions, used by both the bus decode and the channel logic.
package timer_pkg;

   typedef enum logic [1:0] {
      REG_CTRL   = 2'd0,
      REG_RELOAD = 2'd1,
      REG_CNT    = 2'd2,
      REG_STATUS = 2'd3
   } reg_idx_e;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_IE      = 1;
   localparam int CTRL_MODE    = 2;
   localparam int CTRL_PSC_LSB = 8;

endpackage

// File: rtl/timer_chan.sv
// One timer channel: CTRL/RELOAD/CNT/STATUS registers, prescaler and the
// down-counter. Bus writes arrive as per-register strobes from the top level.
module timer_chan
   import timer_pkg::*;
#(
   parameter int W     = 16,
   parameter int PSC_W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_wr_ctrl,
   input  logic         i_wr_reload,
   input  logic         i_wr_cnt,
   input  logic         i_wr_status,
   input  logic [W-1:0] i_wdata,
   output logic [W-1:0] o_ctrl,
   output logic [W-1:0] o_reload,
   output logic [W-1:0] o_cnt,
   output logic [W-1:0] o_status,
   output logic         o_pending,
   output logic         o_int_en
);

   logic             r_en;
   logic             r_ie;
   logic             r_mode;
   logic [PSC_W-1:0] r_psc;
   logic [PSC_W-1:0] r_psc_cnt;
   logic [W-1:0]     r_reload;
   logic [W-1:0]     r_cnt;
   logic             r_pending;

   logic w_tick;
   logic w_event;

   assign w_tick  = r_en && (r_psc_cnt == r_psc);
   assign w_event = w_tick && (r_cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_en      <= 1'b0;
         r_ie      <= 1'b0;
         r_mode    <= 1'b0;
         r_psc     <= '0;
         r_psc_cnt <= '0;
         r_reload  <= '1;
         r_cnt     <= '1;
         r_pending <= 1'b0;
      end else begin
         // A CTRL write overrides the one-shot self-disable and restarts the prescaler phase.
         if (i_wr_ctrl) begin
            r_en      <= i_wdata[CTRL_EN];
            r_ie      <= i_wdata[CTRL_IE];
            r_mode    <= i_wdata[CTRL_MODE];
            r_psc     <= i_wdata[CTRL_PSC_LSB +: PSC_W];
            r_psc_cnt <= '0;
         end else begin
            if (w_event && r_mode) begin
               r_en <= 1'b0;
            end
            if (r_en) begin
               r_psc_cnt <= w_tick ? '0 : r_psc_cnt + PSC_W'(1);
            end
         end

         if (i_wr_reload) begin
            r_reload <= i_wdata;
         end

         if (i_wr_cnt) begin
            r_cnt <= i_wdata;
         end else if (w_tick) begin
            r_cnt <= (r_cnt == '0) ? r_reload : r_cnt - W'(1);
         end

         // Event set takes priority over a simultaneous write-1-to-clear.
         if (w_event) begin
            r_pending <= 1'b1;
         end else if (i_wr_status && i_wdata[0]) begin
            r_pending <= 1'b0;
         end
      end
   end

   always_comb begin
      o_ctrl                            = '0;
      o_ctrl[CTRL_EN]                   = r_en;
      o_ctrl[CTRL_IE]                   = r_ie;
      o_ctrl[CTRL_MODE]                 = r_mode;
      o_ctrl[CTRL_PSC_LSB +: PSC_W]     = r_psc;
   end

   assign o_reload  = r_reload;
   assign o_cnt     = r_cnt;
   assign o_status  = {{(W-1){1'b0}}, r_pending};
   assign o_pending = r_pending;
   assign o_int_en  = r_ie;

endmodule

// File: rtl/timer_bank.sv
// Multi-channel timer peripheral: bus address decode, per-channel write
// strobes, combinational readback and the combined interrupt request.
module timer_bank
   import timer_pkg::*;
#(
   parameter int W     = 16,
   parameter int NCH   = 2,
   parameter int PSC_W = 8,
   parameter int AW    = $clog2(NCH) + 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            sel,
   input  logic            we,
   input  logic            re,
   input  logic [AW-1:0]   addr,
   input  logic [W-1:0]    wdata,
   output logic [W-1:0]    rdata,
   output logic            rdy,
   output logic            int_req,
   output logic [NCH-1:0]  int_vec
);

   localparam int CIW = (AW > 2) ? AW - 2 : 1;

   logic [CIW-1:0] w_ch;
   reg_idx_e       w_reg;
   logic           w_ch_ok;
   logic           w_wr;

   logic [NCH-1:0] w_wr_ctrl;
   logic [NCH-1:0] w_wr_reload;
   logic [NCH-1:0] w_wr_cnt;
   logic [NCH-1:0] w_wr_status;
   logic [NCH-1:0] w_pending;
   logic [NCH-1:0] w_int_en;

   logic [W-1:0] w_ctrl_rd   [NCH];
   logic [W-1:0] w_reload_rd [NCH];
   logic [W-1:0] w_cnt_rd    [NCH];
   logic [W-1:0] w_status_rd [NCH];

   // With a single channel there is no channel field in the address.
   generate
      if (AW > 2) begin : g_ch_field
         assign w_ch = addr[AW-1:2];
      end else begin : g_no_ch_field
         assign w_ch = '0;
      end
   endgenerate

   assign w_reg   = reg_idx_e'(addr[1:0]);
   assign w_ch_ok = int'(w_ch) < NCH;
   assign w_wr    = sel && we && w_ch_ok;

   generate
      for (genvar g = 0; g < NCH; g++) begin : g_chan
         logic w_hit;

         assign w_hit          = w_wr && (int'(w_ch) == g);
         assign w_wr_ctrl[g]   = w_hit && (w_reg == REG_CTRL);
         assign w_wr_reload[g] = w_hit && (w_reg == REG_RELOAD);
         assign w_wr_cnt[g]    = w_hit && (w_reg == REG_CNT);
         assign w_wr_status[g] = w_hit && (w_reg == REG_STATUS);

         timer_chan #(
            .W     (W),
            .PSC_W (PSC_W)
         ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .i_wr_ctrl   (w_wr_ctrl[g]),
            .i_wr_reload (w_wr_reload[g]),
            .i_wr_cnt    (w_wr_cnt[g]),
            .i_wr_status (w_wr_status[g]),
            .i_wdata     (wdata),
            .o_ctrl      (w_ctrl_rd[g]),
            .o_reload    (w_reload_rd[g]),
            .o_cnt       (w_cnt_rd[g]),
            .o_status    (w_status_rd[g]),
            .o_pending   (w_pending[g]),
            .o_int_en    (w_int_en[g])
         );

         assign int_vec[g] = w_pending[g] & w_int_en[g];
      end
   endgenerate

   always_comb begin
      rdata = '0;
      if (sel && re && w_ch_ok) begin
         for (int i = 0; i < NCH; i++) begin
            if (int'(w_ch) == i) begin
               case (w_reg)
                  REG_CTRL:   rdata = w_ctrl_rd[i];
                  REG_RELOAD: rdata = w_reload_rd[i];
                  REG_CNT:    rdata = w_cnt_rd[i];
                  REG_STATUS: rdata = w_status_rd[i];
                  default:    rdata = '0;
               endcase
            end
         end
      end
   end

   assign rdy     = sel;
   assign int_req = |int_vec;

endmodule

// File: tb/tb_timer_bank.sv
// Randomised and directed checks of timer_bank (3 channels, so one channel
// index is out of range) against a cycle-level behavioural model.
module tb_timer_bank;

   localparam int W   = 16;
   localparam int NCH = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          sel;
   logic          we;
   logic          re;
   logic [3:0]    addr;
   logic [W-1:0]  wdata;
   logic [W-1:0]  rdata;
   logic          rdy;
   logic          int_req;
   logic [NCH-1:0] int_vec;

   timer_bank #(.W(W), .NCH(NCH), .PSC_W(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .sel     (sel),
      .we      (we),
      .re      (re),
      .addr    (addr),
      .wdata   (wdata),
      .rdata   (rdata),
      .rdy     (rdy),
      .int_req (int_req),
      .int_vec (int_vec)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int last_cyc;
   logic [NCH-1:0] last_vec;
   logic           last_req;

   // behavioural state of each channel
   int m_en   [NCH];
   int m_ie   [NCH];
   int m_mode [NCH];
   int m_psc  [NCH];
   int m_ph   [NCH];
   int m_rel  [NCH];
   int m_cnt  [NCH];
   int m_pend [NCH];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_en[c] = 0; m_ie[c] = 0; m_mode[c] = 0; m_psc[c] = 0; m_ph[c] = 0;
         m_rel[c] = 16'hFFFF; m_cnt[c] = 16'hFFFF; m_pend[c] = 0;
      end
   endtask

   function automatic logic [NCH-1:0] m_vec();
      logic [NCH-1:0] v = '0;
      for (int c = 0; c < NCH; c++) v[c] = (m_pend[c] != 0) && (m_ie[c] != 0);
      return v;
   endfunction

   function automatic logic [W-1:0] m_rdata(input logic s, input logic r, input logic [3:0] a);
      int c = int'(a[3:2]);
      if (!(s && r) || c >= NCH) return '0;
      case (a[1:0])
         2'd0: return W'(m_en[c] + 2 * m_ie[c] + 4 * m_mode[c] + 256 * m_psc[c]);
         2'd1: return W'(m_rel[c]);
         2'd2: return W'(m_cnt[c]);
         default: return W'(m_pend[c]);
      endcase
   endfunction

   // One clock edge of the model: every channel counts psc+1 cycles per tick and
   // counts down per tick; the tick that finds zero raises pending and reloads.
   task automatic model_step(input logic r, input logic s, input logic w,
                             input logic [3:0] a, input logic [W-1:0] d);
      if (r) begin
         model_reset();
         return;
      end
      for (int c = 0; c < NCH; c++) begin
         bit hit  = s && w && (int'(a[3:2]) == c);
         int rg   = int'(a[1:0]);
         bit tick = (m_en[c] != 0) && (m_ph[c] == m_psc[c]);
         bit fire = tick && (m_cnt[c] == 0);
         if (hit && rg == 2)      m_cnt[c] = int'(d);
         else if (tick)           m_cnt[c] = fire ? m_rel[c] : m_cnt[c] - 1;
         if (hit && rg == 0)      m_ph[c] = 0;
         else if (m_en[c] != 0)   m_ph[c] = tick ? 0 : m_ph[c] + 1;
         if (fire)                m_pend[c] = 1;
         else if (hit && rg == 3 && d[0]) m_pend[c] = 0;
         if (hit && rg == 0) begin
            m_en[c] = int'(d[0]); m_ie[c] = int'(d[1]); m_mode[c] = int'(d[2]);
            m_psc[c] = int'(d[15:8]);
         end else if (fire && m_mode[c] != 0) begin
            m_en[c] = 0;
         end
         if (hit && rg == 1)      m_rel[c] = int'(d);
      end
   endtask

   task automatic bus(input logic s, input logic w, input logic r, input logic [3:0] a,
                      input logic [W-1:0] d, output logic [W-1:0] rd);
      sel = s; we = w; re = r; addr = a; wdata = d;
      @(negedge clk);
      check_eq("rdata", rdata, m_rdata(s, r, a));
      check_eq("rdy", rdy, s);
      check_eq("int_vec", int_vec, m_vec());
      check_eq("int_req", int_req, |m_vec());
      rd = rdata; last_vec = int_vec; last_req = int_req; last_cyc = cyc;
      @(posedge clk);
      model_step(rst, s, w, a, d);
      cyc++;
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [W-1:0] d);
      logic [W-1:0] x;
      bus(1'b1, 1'b1, 1'b0, a, d, x);
   endtask

   task automatic rd(input logic [3:0] a, output logic [W-1:0] v);
      bus(1'b1, 1'b0, 1'b1, a, '0, v);
   endtask

   task automatic idle(input int n);
      logic [W-1:0] x;
      for (int k = 0; k < n; k++) bus(1'b0, 1'b0, 1'b0, 4'h0, '0, x);
   endtask

   // Idles until int_vec[b] is seen high; returns the edge count of that sample.
   task automatic wait_irq(input int b, input int max, output int at);
      logic [W-1:0] x;
      at = -1;
      for (int k = 0; k < max; k++) begin
         bus(1'b0, 1'b0, 1'b0, 4'h0, '0, x);
         if (last_vec[b]) begin
            at = last_cyc;
            break;
         end
      end
      if (at < 0) check_eq("irq_timeout", 0, 1);
   endtask

   initial begin
      logic [W-1:0] v;
      int e0, o1, o2, cnt_ev;
      logic [3:0] a;
      logic [W-1:0] d;

      rst = 1'b1; sel = 0; we = 0; re = 0; addr = '0; wdata = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // reset values
      for (int c = 0; c < 2; c++) begin
         rd(4'(4*c + 0), v); check_eq("rst_ctrl", v, 16'h0000);
         rd(4'(4*c + 1), v); check_eq("rst_reload", v, 16'hFFFF);
         rd(4'(4*c + 2), v); check_eq("rst_cnt", v, 16'hFFFF);
         rd(4'(4*c + 3), v); check_eq("rst_status", v, 16'h0000);
      end

      // periodic, psc 0, reload 3
      wr(4'h1, 16'd3); wr(4'h2, 16'd3); wr(4'h0, 16'h0003); e0 = cyc;
      wait_irq(0, 20, o1); check_eq("per_first", 32'(o1 - e0), 4);
      wr(4'h3, 16'h0001);
      wait_irq(0, 20, o2); check_eq("per_period", 32'(o2 - o1), 4);

      // prescaled, reload 1 psc 2, then phase restart by CTRL rewrite
      wr(4'h0, 16'h0000); wr(4'h3, 16'h0001);
      wr(4'h1, 16'd1); wr(4'h2, 16'd1); wr(4'h0, 16'h0203); e0 = cyc;
      wait_irq(0, 30, o1); check_eq("psc_first", 32'(o1 - e0), 6);
      wr(4'h3, 16'h0001);
      wait_irq(0, 30, o2); check_eq("psc_period", 32'(o2 - o1), 6);
      wr(4'h3, 16'h0001); wr(4'h0, 16'h0203); e0 = cyc;
      wait_irq(0, 30, o1); check_eq("psc_restart", 32'(o1 - e0), 3);
      wr(4'h0, 16'h0000); wr(4'h3, 16'h0001);

      // one-shot on ch1
      wr(4'h5, 16'd5); wr(4'h6, 16'd5); wr(4'h4, 16'h0007); e0 = cyc;
      wait_irq(1, 30, o1); check_eq("os_delay", 32'(o1 - e0), 6);
      rd(4'h4, v); check_eq("os_ctrl", v, 16'h0006);
      rd(4'h6, v); check_eq("os_cnt", v, 16'd5);
      wr(4'h7, 16'h0001);
      cnt_ev = 0;
      for (int k = 0; k < 50; k++) begin
         idle(1);
         if (last_vec[1]) cnt_ev++;
      end
      check_eq("os_no_more", 32'(cnt_ev), 0);

      // W1C on event edge, CNT write on tick
      wr(4'h1, 16'd3); wr(4'h2, 16'd3); wr(4'h0, 16'h0003);
      idle(3); wr(4'h3, 16'h0001);
      rd(4'h3, v); check_eq("w1c_vs_event", v, 16'h0001);
      wr(4'h2, 16'h0010);
      rd(4'h2, v); check_eq("cnt_wr_tick", v, 16'h0010);

      // pending without int_en, then enable
      wr(4'h3, 16'h0001); wr(4'h0, 16'h0001);
      idle(25);
      rd(4'h3, v); check_eq("ie0_pending", v, 16'h0001);
      check_eq("ie0_int_req", last_req, 1'b0);
      wr(4'h0, 16'h0003);
      idle(1);
      check_eq("ie1_int_vec", last_vec, 3'b001);
      check_eq("ie1_int_req", last_req, 1'b1);

      // out-of-range channel 3
      for (int r = 0; r < 4; r++) wr(4'(12 + r), 16'h1234);
      for (int r = 0; r < 4; r++) begin
         rd(4'(12 + r), v); check_eq("oor_read", v, 16'h0000);
      end
      rd(4'h1, v); check_eq("oor_ch0_reload", v, 16'd3);
      rd(4'h5, v); check_eq("oor_ch1_reload", v, 16'd5);

      // reset mid-count
      rst = 1'b1; idle(1); rst = 1'b0;
      rd(4'h0, v); check_eq("mid_rst_ctrl", v, 16'h0000);
      rd(4'h2, v); check_eq("mid_rst_cnt", v, 16'hFFFF);

      // random traffic against the model
      for (int k = 0; k < 1500; k++) begin
         int op = $urandom_range(0, 19);
         a = 4'($urandom_range(0, 15));
         case (a[1:0])
            2'd0:    d = W'(($urandom_range(0, 3) << 8) | $urandom_range(0, 7));
            2'd3:    d = W'($urandom_range(0, 3));
            default: d = W'($urandom_range(0, 9));
         endcase
         if (op == 0) begin
            rst = 1'b1; idle(1); rst = 1'b0;
         end else if (op < 9) begin
            wr(a, d);
         end else if (op < 15) begin
            rd(a, v);
         end else begin
            bus(1'b0, 1'(op[0]), 1'(op[1]), a, d, v);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
